// File: rtl/prod_accum_stage.sv
// Product accumulator: sums unsigned products into groups of LEN (or fewer on flush), one result per group.
// Latency: result is registered one cycle after the closing accept or flush.
// Backpressure: prod_ready = ~sum_valid | sum_ready; all state is frozen while a result waits (HOLD).
// Optional: define PROD_ACCUM_SAT_EN to saturate the accumulator on carry instead of wrapping.
module prod_accum_stage #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 36,
    parameter int LEN    = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  sum_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              ovf_out,
    output logic              sum_valid,
    input  logic              sum_ready
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic             accept;
    logic [ACC_W:0]   add_term;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             close_full;
    logic             close_flush;
    logic             close_grp;

    // Handshake, next accumulator value and group-close decision.
    always_comb begin
        prod_ready  = ~sum_valid | sum_ready;
        accept      = prod_valid & prod_ready;
        add_term    = '0;
        if (accept) begin
            add_term = {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
        end
        sum_ext     = {1'b0, acc} + add_term;
        carry       = sum_ext[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        // Once saturated, any further nonzero product carries again, so the
        // accumulator stays pinned at all-ones for the rest of the group.
        nxt         = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        nxt         = sum_ext[ACC_W-1:0];
`endif
        cnt_inc     = cnt + CNT_W'(accept);
        close_full  = accept & (cnt_inc == LEN_C);
        close_flush = flush & prod_ready & (cnt_inc != '0);
        close_grp   = close_full | close_flush;
    end

    // Accumulator, counter and sticky overflow for the group in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (close_grp) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (accept) begin
            acc    <= nxt;
            cnt    <= cnt_inc;
            sticky <= sticky | carry;
        end
    end

    // Result register: loaded on group close, released when the sink takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_out   <= '0;
            cnt_out   <= '0;
            ovf_out   <= 1'b0;
            sum_valid <= 1'b0;
        end else if (close_grp) begin
            sum_out   <= nxt;
            cnt_out   <= cnt_inc;
            ovf_out   <= sticky | carry;
            sum_valid <= 1'b1;
        end else if (sum_valid & sum_ready) begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prod_accum_stage.sv
// Directed bench for prod_accum_stage: default instance plus a 20-bit accumulator instance for overflow.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_prod_accum_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [17:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic        flush = 1'b0;
    logic [35:0] sum_out;
    logic [3:0]  cnt_out;
    logic        ovf_out;
    logic        sum_valid;
    logic        sum_ready = 1'b0;

    logic [17:0] o_prod_in = '0;
    logic        o_prod_valid = 1'b0;
    logic        o_prod_ready;
    logic        o_flush = 1'b0;
    logic [19:0] o_sum_out;
    logic [3:0]  o_cnt_out;
    logic        o_ovf_out;
    logic        o_sum_valid;
    logic        o_sum_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    prod_accum_stage dut (
        .clock(clock), .reset(reset),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .flush(flush),
        .sum_out(sum_out), .cnt_out(cnt_out), .ovf_out(ovf_out),
        .sum_valid(sum_valid), .sum_ready(sum_ready)
    );

    prod_accum_stage #(.PROD_W(18), .ACC_W(20), .LEN(8), .CNT_W(4)) dut_ovf (
        .clock(clock), .reset(reset),
        .prod_in(o_prod_in), .prod_valid(o_prod_valid), .prod_ready(o_prod_ready),
        .flush(o_flush),
        .sum_out(o_sum_out), .cnt_out(o_cnt_out), .ovf_out(o_ovf_out),
        .sum_valid(o_sum_valid), .sum_ready(o_sum_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL reset_sum_valid got %0b want 0", sum_valid); end
        tests++; if (sum_out !== 36'd0) begin fails++; $display("FAIL reset_sum_out got %0d want 0", sum_out); end
        tests++; if (cnt_out !== 4'd0) begin fails++; $display("FAIL reset_cnt_out got %0d want 0", cnt_out); end
        tests++; if (ovf_out !== 1'b0) begin fails++; $display("FAIL reset_ovf_out got %0b want 0", ovf_out); end
        tests++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL reset_prod_ready got %0b want 1", prod_ready); end
        tests++; if (o_sum_valid !== 1'b0) begin fails++; $display("FAIL reset_o_sum_valid got %0b want 0", o_sum_valid); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        sum_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            prod_in = 18'(i);
            prod_valid = 1'b1;
            tick();
            if (i < 8) begin
                tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid at %0d got %0b want 0", i, sum_valid); end
            end
        end
        tests++; if (sum_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", sum_valid); end
        tests++; if (sum_out !== 36'd36) begin fails++; $display("FAIL basic_sum got %0d want 36", sum_out); end
        tests++; if (cnt_out !== 4'd8) begin fails++; $display("FAIL basic_cnt got %0d want 8", cnt_out); end
        tests++; if (ovf_out !== 1'b0) begin fails++; $display("FAIL basic_ovf got %0b want 0", ovf_out); end
        // 9th product lands in the next group while the result is taken.
        prod_in = 18'd9;
        #1;
        tests++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL basic_9th_ready got %0b want 1", prod_ready); end
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_pulse got %0b want 0", sum_valid); end
        for (int i = 10; i <= 16; i++) begin
            prod_in = 18'(i);
            tick();
        end
        tests++; if (sum_out !== 36'd100 || sum_valid !== 1'b1) begin fails++; $display("FAIL basic_group2 got sum %0d valid %0b want 100/1", sum_out, sum_valid); end
        tests++; if (cnt_out !== 4'd8) begin fails++; $display("FAIL basic_group2_cnt got %0d want 8", cnt_out); end
        prod_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        sum_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            prod_in = 18'(i);
            prod_valid = 1'b1;
            tick();
        end
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd36) begin fails++; $display("FAIL bp_result got valid %0b sum %0d want 1/36", sum_valid, sum_out); end
        prod_in = 18'd10;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL bp_ready cycle %0d got %0b want 0", c, prod_ready); end
            tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd36 || cnt_out !== 4'd8) begin fails++; $display("FAIL bp_hold cycle %0d got valid %0b sum %0d cnt %0d want 1/36/8", c, sum_valid, sum_out, cnt_out); end
            tick();
        end
        sum_ready = 1'b1;
        #1;
        tests++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", prod_ready); end
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %0b want 0", sum_valid); end
        // Close the group holding the stalled product to prove it was taken once.
        prod_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd10 || cnt_out !== 4'd1) begin fails++; $display("FAIL bp_stalled_product got valid %0b sum %0d cnt %0d want 1/10/1", sum_valid, sum_out, cnt_out); end
        tick();
    endtask

    task automatic test_flush();
        sum_ready = 1'b1;
        prod_valid = 1'b1;
        prod_in = 18'd100; tick();
        prod_in = 18'd200; tick();
        prod_in = 18'd300; flush = 1'b1; tick();
        prod_valid = 1'b0;
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd600) begin fails++; $display("FAIL flush_sum got valid %0b sum %0d want 1/600", sum_valid, sum_out); end
        tests++; if (cnt_out !== 4'd3) begin fails++; $display("FAIL flush_cnt got %0d want 3", cnt_out); end
        // Flush with an empty group emits nothing.
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_1 got %0b want 0", sum_valid); end
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_2 got %0b want 0", sum_valid); end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        sum_ready = 1'b1;
        prod_valid = 1'b1;
        flush = 1'b1;
        prod_in = 18'd5; tick();
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd5 || cnt_out !== 4'd1) begin fails++; $display("FAIL b2b_first got valid %0b sum %0d cnt %0d want 1/5/1", sum_valid, sum_out, cnt_out); end
        prod_in = 18'd7; tick();
        prod_valid = 1'b0;
        flush = 1'b0;
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd7 || cnt_out !== 4'd1) begin fails++; $display("FAIL b2b_second got valid %0b sum %0d cnt %0d want 1/7/1", sum_valid, sum_out, cnt_out); end
        tick();
        tests++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL b2b_drop got %0b want 0", sum_valid); end
    endtask

    task automatic test_overflow();
        logic [19:0] exp_sum;
`ifdef PROD_ACCUM_SAT_EN
        exp_sum = 20'hFFFFF;
`else
        exp_sum = 20'hFFFF8;
`endif
        o_sum_ready = 1'b1;
        o_prod_valid = 1'b1;
        o_prod_in = 18'h3FFFF;
        for (int i = 0; i < 8; i++) tick();
        o_prod_valid = 1'b0;
        tests++; if (o_sum_valid !== 1'b1 || o_sum_out !== exp_sum) begin fails++; $display("FAIL ovf_sum got valid %0b sum %h want 1/%h", o_sum_valid, o_sum_out, exp_sum); end
        tests++; if (o_ovf_out !== 1'b1 || o_cnt_out !== 4'd8) begin fails++; $display("FAIL ovf_flag got ovf %0b cnt %0d want 1/8", o_ovf_out, o_cnt_out); end
        // Sticky flag must not leak into the next group.
        o_prod_valid = 1'b1;
        o_prod_in = 18'd1;
        o_flush = 1'b1;
        tick();
        o_prod_valid = 1'b0;
        o_flush = 1'b0;
        tests++; if (o_sum_valid !== 1'b1 || o_sum_out !== 20'd1 || o_ovf_out !== 1'b0) begin fails++; $display("FAIL ovf_clear got valid %0b sum %0d ovf %0b want 1/1/0", o_sum_valid, o_sum_out, o_ovf_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        sum_ready = 1'b1;
        // Leave a nonzero result in the output register before the reset.
        prod_valid = 1'b1;
        flush = 1'b1;
        prod_in = 18'd42; tick();
        flush = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            prod_in = 18'(i);
            tick();
        end
        prod_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (sum_valid !== 1'b0 || sum_out !== 36'd0 || cnt_out !== 4'd0 || ovf_out !== 1'b0) begin fails++; $display("FAIL rmid_outputs got valid %0b sum %0d cnt %0d ovf %0b want 0/0/0/0", sum_valid, sum_out, cnt_out, ovf_out); end
        tests++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %0b want 1", prod_ready); end
        prod_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            prod_in = 18'(i);
            tick();
        end
        prod_valid = 1'b0;
        tests++; if (sum_valid !== 1'b1 || sum_out !== 36'd36 || cnt_out !== 4'd8) begin fails++; $display("FAIL rmid_group got valid %0b sum %0d cnt %0d want 1/36/8", sum_valid, sum_out, cnt_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prod_accum_stage.md
Name: prod_accum_stage

Overview:
- Downstream consumer of the registered multiplier outputs (e.g. the 18-bit product of two 9-bit operands).
- Accumulates a stream of unsigned products into groups of LEN products, or fewer if flushed early, and produces one ACC_W-bit dot-product result per group.
- Input and output both use valid/ready handshakes, so the block can sit between a multiplier stage and a result sink that applies backpressure.

Parameters:
- PROD_W, 18: width of incoming product.
- ACC_W, 36: width of accumulator and result; must be >= PROD_W.
- LEN, 8: products per group; must be >= 2.
- CNT_W, 4: width of the product counter; must hold the value LEN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- prod_in  input  PROD_W  unsigned product.
- prod_valid  input  1  prod_in is valid.
- prod_ready  output  1  block accepts prod_in this cycle.
- flush  input  1  close the current group early.
- sum_out  output  ACC_W  group result.
- cnt_out  output  CNT_W  number of products in the reported group.
- ovf_out  output  1  accumulation overflowed within the reported group.
- sum_valid  output  1  sum_out, cnt_out and ovf_out are valid.
- sum_ready  input  1  sink accepts the result.

Behaviour:
- Clock and reset: single clock, clock. Reset is synchronous and active-high on reset.
- Reset: sets acc, cnt, the sticky overflow flag, sum_out, cnt_out, ovf_out and sum_valid to 0. Reset mid-group discards the partial sum.
- Handshake rules:
  - prod_ready = ~sum_valid | sum_ready (combinational).
  - accept = prod_valid & prod_ready.
  - Result is taken when sum_valid & sum_ready.
- Two states:
  - ACCUM: sum_valid=0, or the result is being taken this cycle.
  - HOLD: sum_valid=1 & ~sum_ready. Internal state frozen; prod_in and flush are ignored.
- Arithmetic: nxt = acc + (accept ? zero-extended prod_in : 0), computed ACC_W+1 bits wide. Bit ACC_W is the carry and sets the sticky overflow flag. Without SAT_EN the sum wraps modulo 2^ACC_W.
- Group close: a group closes when either
  - accept and cnt+1 == LEN, or
  - flush & prod_ready & (cnt + accept) > 0.
- On close (next edge):
  - sum_out <= nxt; cnt_out <= cnt + accept; ovf_out <= sticky | carry; sum_valid <= 1.
  - acc, cnt and sticky are cleared.
- Otherwise, on accept: acc <= nxt, cnt <= cnt+1, sticky |= carry.
- Latency: the result is visible one cycle after the closing accept or flush.
- Simultaneous accept and flush: the product is included, then the group closes.
- Flush with cnt=0 and no accept: ignored, no result emitted.
- sum_ready=1 while sum_valid=1: sum_valid drops next cycle unless a new group closes in the same cycle. Back-to-back results are possible only on flush, since LEN >= 2.
- Products accepted while a result is being taken start the next group. Throughput is 1 product/cycle with no bubbles when sum_ready=1.

Optional Feature:
- Macro: PROD_ACCUM_SAT_EN.
- Defined: on carry, acc saturates to 2^ACC_W-1 and stays there for the rest of the group. ovf_out is still reported.
- Undefined: the sum wraps modulo 2^ACC_W and ovf_out flags the wrap.

Test Plan:
- Defaults, sum_ready=1, products 1..8 on consecutive cycles:
  - sum_out=36, cnt_out=8, ovf_out=0, sum_valid pulsed 1 cycle after the 8th accept.
  - A 9th product in the next cycle is accepted into a new group.
- Backpressure:
  - Complete a group with sum_ready=0 for 5 cycles.
  - prod_ready=0 throughout, sum_out held stable, a 10th product is stalled.
  - Raise sum_ready: the product is accepted that cycle and sum_valid drops.
- Early flush:
  - Products 100, 200, 300, with flush asserted alongside 300: sum_out=600, cnt_out=3.
  - Flush alone with cnt=0: no sum_valid.
- Overflow (ACC_W=20):
  - 8 products of 0x3FFFF: sum_out=0xFFFF8, ovf_out=1.
  - With PROD_ACCUM_SAT_EN: sum_out=0xFFFFF, ovf_out=1.
- Reset:
  - Assert reset after 5 of 8 products.
  - Next cycle: all outputs 0, prod_ready=1.
  - Products 1..8 then yield sum_out=36, with no residue from the aborted group.
